// File: rtl/bpc_pkg.sv
// Shared types and elaboration-time helpers for the streaming population counter.
package bpc_pkg;

  typedef enum logic {BPC_ONES, BPC_ZEROS} bpc_mode_t;

  function automatic int unsigned cnt_w(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic int unsigned num_groups(input int unsigned width);
    return (width + 3) / 4;
  endfunction

  function automatic int unsigned tree_levels(input int unsigned width);
    return $clog2(num_groups(width));
  endfunction

  function automatic int unsigned latency(input int unsigned width, input int unsigned lps);
    return (tree_levels(width) + lps - 1) / lps + 1;
  endfunction

  // Operand count remaining after `level` pairwise-add levels.
  function automatic int unsigned ops_at(input int unsigned width, input int unsigned level);
    int unsigned n;
    n = num_groups(width);
    for (int unsigned i = 0; i < level; i++) n = (n + 1) / 2;
    return n;
  endfunction

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return {2'b0, v[0]} + {2'b0, v[1]} + {2'b0, v[2]} + {2'b0, v[3]};
  endfunction

endpackage

// File: rtl/bit_population_counter_stream_adder_stage.sv
// One combinational pairwise-add level of the count tree; an odd last operand passes through.
module bpc_adder_stage #(
  parameter int unsigned NumOps = 2,
  parameter int unsigned OpW = 3,
  localparam int unsigned NumSums = (NumOps + 1) / 2
) (
  input  logic [NumOps*OpW-1:0]      ops_i,
  output logic [NumSums*(OpW+1)-1:0] sums_o
);

  for (genvar j = 0; j < NumSums; j++) begin : g_sum
    if (2 * j + 1 < NumOps) begin : g_add
      assign sums_o[j*(OpW+1) +: OpW+1] = {1'b0, ops_i[2*j*OpW +: OpW]}
                                        + {1'b0, ops_i[(2*j+1)*OpW +: OpW]};
    end else begin : g_pass
      assign sums_o[j*(OpW+1) +: OpW+1] = {1'b0, ops_i[2*j*OpW +: OpW]};
    end
  end

endmodule

// File: rtl/bit_population_counter_stream.sv
// Streaming popcount: leaf nibble counts feed a pipelined adder tree with global-stall
// backpressure, plus a saturating per-packet running total on the output stage.
module bit_population_counter_stream
  import bpc_pkg::*;
#(
  parameter int unsigned WIDTH = 24,
  parameter int unsigned LEVELS_PER_STAGE = 1,
  parameter int unsigned ACC_WIDTH = 16,
  localparam int unsigned CNT_W = cnt_w(WIDTH)
) (
  input  logic                 clk_i,
  input  logic                 srst_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic                 mode_i,
  input  logic                 data_last_i,
  input  logic                 data_val_i,
  output logic                 data_ready_o,
  output logic [CNT_W-1:0]     data_o,
  output logic                 data_last_o,
  output logic                 data_val_o,
  input  logic                 data_ready_i,
  output logic [ACC_WIDTH-1:0] acc_o,
  output logic                 acc_sat_o
);

  localparam int unsigned G  = num_groups(WIDTH);
  localparam int unsigned L  = tree_levels(WIDTH);
  localparam int unsigned TW = L + 3;

  logic stall;
  assign stall        = data_val_o & ~data_ready_i;
  assign data_ready_o = ~stall;

  // Pad bits stay zero in both modes so they never contribute to the count.
  logic [4*G-1:0] word;
  always_comb begin
    word = '0;
    word[WIDTH-1:0] = (bpc_mode_t'(mode_i) == BPC_ZEROS) ? ~data_i : data_i;
  end

  // lvl_c: combinational result of level k; lvl_v: the same after an optional register.
  logic [TW-1:0] lvl_c [L+1][G];
  logic [TW-1:0] lvl_v [L+1][G];
  logic          vld_v [L+1];
  logic          last_v [L+1];
  logic          out_vld_d, out_last_d;

  for (genvar j = 0; j < G; j++) begin : g_leaf
    assign lvl_c[0][j] = TW'(popcnt4(word[4*j +: 4]));
  end

  for (genvar k = 1; k <= L; k++) begin : g_tree
    localparam int unsigned NIn  = ops_at(WIDTH, k - 1);
    localparam int unsigned NOut = ops_at(WIDTH, k);
    localparam int unsigned OpW  = k + 2;

    logic [NIn*OpW-1:0]      ops;
    logic [NOut*(OpW+1)-1:0] sums;

    for (genvar j = 0; j < NIn; j++) begin : g_pack
      assign ops[j*OpW +: OpW] = lvl_v[k-1][j][OpW-1:0];
    end

    bpc_adder_stage #(
      .NumOps (NIn),
      .OpW    (OpW)
    ) u_stage (
      .ops_i  (ops),
      .sums_o (sums)
    );

    for (genvar j = 0; j < G; j++) begin : g_unpack
      if (j < NOut) begin : g_used
        assign lvl_c[k][j] = TW'(sums[j*(OpW+1) +: OpW+1]);
      end else begin : g_zero
        assign lvl_c[k][j] = '0;
      end
    end
  end

  for (genvar k = 0; k <= L; k++) begin : g_pipe
    logic vin, lin;
    if (k == 0) begin : g_in0
      assign vin = data_val_i;
      assign lin = data_last_i;
    end else begin : g_ink
      assign vin = vld_v[k-1];
      assign lin = last_v[k-1];
    end

    if (k == L) begin : g_tap
      assign out_vld_d  = vin;
      assign out_last_d = lin;
    end

    // Leaf counts, every LEVELS_PER_STAGE-th level and the final level are registered.
    if (k == 0 || k == L || (k % LEVELS_PER_STAGE) == 0) begin : g_reg
      logic [TW-1:0] cnt_q [G];
      logic          vld_q, last_q;

      always_ff @(posedge clk_i or posedge srst_i) begin
        if (srst_i) begin
          for (int j = 0; j < G; j++) cnt_q[j] <= '0;
          vld_q  <= 1'b0;
          last_q <= 1'b0;
        end else if (!stall) begin
          for (int j = 0; j < G; j++) cnt_q[j] <= lvl_c[k][j];
          vld_q  <= vin;
          last_q <= lin;
        end
      end

      for (genvar j = 0; j < G; j++) begin : g_out
        assign lvl_v[k][j] = cnt_q[j];
      end
      assign vld_v[k]  = vld_q;
      assign last_v[k] = last_q;
    end else begin : g_wire
      for (genvar j = 0; j < G; j++) begin : g_out
        assign lvl_v[k][j] = lvl_c[k][j];
      end
      assign vld_v[k]  = vin;
      assign last_v[k] = lin;
    end
  end

  assign data_o      = lvl_v[L][0][CNT_W-1:0];
  assign data_val_o  = vld_v[L];
  assign data_last_o = last_v[L];

  logic [CNT_W-1:0]     cnt_d;
  logic [ACC_WIDTH:0]   acc_sum;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 sat_q, sat_d;
  logic                 first_q, first_d;

  assign cnt_d = lvl_c[L][0][CNT_W-1:0];

  always_comb begin
    acc_d   = acc_q;
    sat_d   = sat_q;
    first_d = first_q;
    acc_sum = {1'b0, acc_q} + (ACC_WIDTH+1)'(cnt_d);
    if (!stall && out_vld_d) begin
      first_d = out_last_d;
      if (first_q) begin
        acc_d = ACC_WIDTH'(cnt_d);
        sat_d = 1'b0;
      end else if (acc_sum[ACC_WIDTH]) begin
        acc_d = '1;
        sat_d = 1'b1;
      end else begin
        acc_d = acc_sum[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or posedge srst_i) begin
    if (srst_i) begin
      acc_q   <= '0;
      sat_q   <= 1'b0;
      first_q <= 1'b1;
    end else begin
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      first_q <= first_d;
    end
  end

  assign acc_o     = acc_q;
  assign acc_sat_o = sat_q;

endmodule

// File: tb/tb_bit_population_counter_stream.sv
// Bench for bit_population_counter_stream: scoreboard model on the main instance plus
// directed literal checks on small-width, two-level-per-stage and narrow-accumulator builds.
module tb_bit_population_counter_stream;
  import bpc_pkg::*;

  logic clk = 1'b0;
  logic srst = 1'b1;
  logic one = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errs = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Main instance: WIDTH 24, LPS 1, ACC 16
  logic [23:0] m_data = '0;
  logic        m_mode = 1'b0, m_last = 1'b0, m_val = 1'b0, m_rdy_i = 1'b1;
  logic        m_rdy_o, m_last_o, m_val_o, m_sat;
  logic [4:0]  m_dout;
  logic [15:0] m_acc;

  bit_population_counter_stream #(.WIDTH(24), .LEVELS_PER_STAGE(1), .ACC_WIDTH(16)) u_main (
    .clk_i(clk), .srst_i(srst), .data_i(m_data), .mode_i(m_mode), .data_last_i(m_last),
    .data_val_i(m_val), .data_ready_o(m_rdy_o), .data_o(m_dout), .data_last_o(m_last_o),
    .data_val_o(m_val_o), .data_ready_i(m_rdy_i), .acc_o(m_acc), .acc_sat_o(m_sat)
  );

  // WIDTH 4: no tree levels, output register only
  logic [3:0]  w4_data = '0;
  logic        w4_mode = 1'b0, w4_last = 1'b0, w4_val = 1'b0;
  logic        w4_rdy_o, w4_last_o, w4_val_o, w4_sat;
  logic [2:0]  w4_dout;
  logic [15:0] w4_acc;

  bit_population_counter_stream #(.WIDTH(4), .LEVELS_PER_STAGE(1), .ACC_WIDTH(16)) u_w4 (
    .clk_i(clk), .srst_i(srst), .data_i(w4_data), .mode_i(w4_mode), .data_last_i(w4_last),
    .data_val_i(w4_val), .data_ready_o(w4_rdy_o), .data_o(w4_dout), .data_last_o(w4_last_o),
    .data_val_o(w4_val_o), .data_ready_i(one), .acc_o(w4_acc), .acc_sat_o(w4_sat)
  );

  // WIDTH 22 with two levels per stage
  logic [21:0] w22_data = '0;
  logic        w22_mode = 1'b0, w22_last = 1'b0, w22_val = 1'b0;
  logic        w22_rdy_o, w22_last_o, w22_val_o, w22_sat;
  logic [4:0]  w22_dout;
  logic [15:0] w22_acc;

  bit_population_counter_stream #(.WIDTH(22), .LEVELS_PER_STAGE(2), .ACC_WIDTH(16)) u_w22 (
    .clk_i(clk), .srst_i(srst), .data_i(w22_data), .mode_i(w22_mode), .data_last_i(w22_last),
    .data_val_i(w22_val), .data_ready_o(w22_rdy_o), .data_o(w22_dout),
    .data_last_o(w22_last_o), .data_val_o(w22_val_o), .data_ready_i(one), .acc_o(w22_acc),
    .acc_sat_o(w22_sat)
  );

  // Narrow accumulator to reach saturation
  logic [23:0] s_data = '0;
  logic        s_mode = 1'b0, s_last = 1'b0, s_val = 1'b0;
  logic        s_rdy_o, s_last_o, s_val_o, s_sat;
  logic [4:0]  s_dout;
  logic [4:0]  s_acc;

  bit_population_counter_stream #(.WIDTH(24), .LEVELS_PER_STAGE(1), .ACC_WIDTH(5)) u_sat (
    .clk_i(clk), .srst_i(srst), .data_i(s_data), .mode_i(s_mode), .data_last_i(s_last),
    .data_val_i(s_val), .data_ready_o(s_rdy_o), .data_o(s_dout), .data_last_o(s_last_o),
    .data_val_o(s_val_o), .data_ready_i(one), .acc_o(s_acc), .acc_sat_o(s_sat)
  );

  // Model of the main instance: expectations computed at acceptance, consumed in order.
  typedef struct {
    int cnt;
    bit last;
    int acc;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   log_acc[$];
  bit   log_last[$];
  bit   mdl_first = 1'b1;
  int   mdl_acc = 0;
  bit   mdl_sat = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (srst) begin
        exp_q.delete();
        mdl_first = 1'b1;
        mdl_acc = 0;
        mdl_sat = 1'b0;
      end else begin
        check("ready_o", m_rdy_o, !(m_val_o && !m_rdy_i));
        if (m_val_o) begin
          if (exp_q.size() == 0) begin
            checks++;
            errs++;
            $display("FAIL unexpected_beat: got count %0d expected no beat", m_dout);
          end else begin
            check("sb_cnt", m_dout, exp_q[0].cnt);
            check("sb_last", m_last_o, exp_q[0].last);
            check("sb_acc", m_acc, exp_q[0].acc);
            check("sb_sat", m_sat, exp_q[0].sat);
            if (m_rdy_i) begin
              void'(exp_q.pop_front());
              log_acc.push_back(int'(m_acc));
              log_last.push_back(m_last_o);
            end
          end
        end
        if (m_val && m_rdy_o) begin
          exp_t e;
          e.cnt = $countones(m_mode ? ~m_data : m_data);
          e.last = m_last;
          if (mdl_first) begin
            mdl_acc = e.cnt;
            mdl_sat = 1'b0;
          end else if (mdl_acc + e.cnt > 65535) begin
            mdl_acc = 65535;
            mdl_sat = 1'b1;
          end else begin
            mdl_acc = mdl_acc + e.cnt;
          end
          mdl_first = m_last;
          e.acc = mdl_acc;
          e.sat = mdl_sat;
          exp_q.push_back(e);
        end
      end
    end
  end

  int s_log_acc[$];
  bit s_log_sat[$];
  initial begin
    forever begin
      @(negedge clk);
      if (!srst && s_val_o) begin
        s_log_acc.push_back(int'(s_acc));
        s_log_sat.push_back(s_sat);
      end
    end
  end

  task automatic put(input logic [23:0] d, input logic md, input logic lst);
    int n;
    m_data = d;
    m_mode = md;
    m_last = lst;
    m_val = 1'b1;
    n = 0;
    @(negedge clk);
    while (!m_rdy_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (n >= 100) begin
      checks++;
      errs++;
      $display("FAIL put_timeout: got no ready in %0d cycles expected ready", n);
    end
    @(posedge clk);
    #1;
    m_val = 1'b0;
  endtask

  task automatic wait_main_val(output int k);
    k = 0;
    while (!m_val_o && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errs++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int k;
    int pk_acc[4] = '{1, 3, 6, 5};
    bit pk_last[4] = '{1'b0, 1'b0, 1'b1, 1'b1};

    repeat (3) @(posedge clk);
    #3 srst = 1'b0;
    @(negedge clk);
    check("rst_val", m_val_o, 0);
    check("rst_dout", m_dout, 0);
    check("rst_last", m_last_o, 0);
    check("rst_acc", m_acc, 0);
    check("rst_sat", m_sat, 0);
    check("rst_ready", m_rdy_o, 1);
    @(posedge clk);
    #1;

    // All ones, latency LAT-1 edges after the accepting edge
    put(24'hFFFFFF, 1'b0, 1'b1);
    wait_main_val(k);
    check("lat24", k, latency(24, 1) - 1);
    check("lat24_lit", k, 3);
    check("ones_cnt", m_dout, 24);
    check("ones_acc", m_acc, 24);
    wait_drain();

    put(24'h00000F, 1'b1, 1'b1);
    wait_main_val(k);
    check("zeros_cnt", m_dout, 20);
    check("zeros_acc", m_acc, 20);
    wait_drain();

    // WIDTH 4: visible right after the accepting edge
    w4_data = 4'hF; w4_mode = 1'b0; w4_last = 1'b1; w4_val = 1'b1;
    @(posedge clk);
    #1;
    w4_data = 4'h5; w4_mode = 1'b1;
    check("w4_val", w4_val_o, 1);
    check("w4_cnt", w4_dout, 4);
    check("w4_acc", w4_acc, 4);
    @(posedge clk);
    #1;
    w4_val = 1'b0;
    check("w4_zeros_cnt", w4_dout, 2);
    check("w4_zeros_acc", w4_acc, 2);

    // WIDTH 22, two levels per stage: pad bits excluded in zero mode
    w22_data = '0; w22_mode = 1'b1; w22_last = 1'b1; w22_val = 1'b1;
    @(posedge clk);
    #1;
    w22_val = 1'b0;
    @(posedge clk);
    #1;
    check("w22_early", w22_val_o, 0);
    @(posedge clk);
    #1;
    check("w22_val", w22_val_o, 1);
    check("w22_cnt", w22_dout, 22);
    check("w22_acc", w22_acc, 22);

    // Saturation with a 5-bit accumulator
    s_data = 24'hFFFFFF; s_mode = 1'b0; s_last = 1'b0; s_val = 1'b1;
    @(posedge clk);
    #1;
    s_last = 1'b1;
    @(posedge clk);
    #1;
    s_data = 24'h000007;
    @(posedge clk);
    #1;
    s_val = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("sat_n", s_log_acc.size(), 3);
    if (s_log_acc.size() == 3) begin
      check("sat_acc0", s_log_acc[0], 24);
      check("sat_flag0", s_log_sat[0], 0);
      check("sat_acc1", s_log_acc[1], 31);
      check("sat_flag1", s_log_sat[1], 1);
      check("sat_acc2", s_log_acc[2], 3);
      check("sat_flag2", s_log_sat[2], 0);
    end

    // Packet of counts 1,2,3 then a single-beat packet of 5
    log_acc.delete();
    log_last.delete();
    put(24'h000001, 1'b0, 1'b0);
    put(24'h000003, 1'b0, 1'b0);
    put(24'h000007, 1'b0, 1'b1);
    put(24'h00001F, 1'b0, 1'b1);
    wait_drain();
    check("pkt_n", log_acc.size(), 4);
    if (log_acc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check($sformatf("pkt_acc%0d", i), log_acc[i], pk_acc[i]);
        check($sformatf("pkt_last%0d", i), log_last[i], pk_last[i]);
      end
    end

    // Continuous stream with a 5-cycle downstream stall
    log_acc.delete();
    log_last.delete();
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          put(24'(i * 32'h0093_1F07), (i % 3) == 1, ((i % 4) == 3) || (i == 11));
        end
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        m_rdy_i = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("stall_ready", m_rdy_o, 0);
          check("stall_val", m_val_o, 1);
        end
        @(posedge clk);
        #1;
        m_rdy_i = 1'b1;
      end
    join
    wait_drain();
    check("stream_n", log_acc.size(), 12);

    // Reset mid-flight
    put(24'h000FFF, 1'b0, 1'b0);
    put(24'h0000FF, 1'b0, 1'b0);
    put(24'h00000F, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    check("pre_rst_val", m_val_o, 1);
    check("pre_rst_acc", m_acc, 12);
    #2 srst = 1'b1;
    #1;
    check("mid_rst_val", m_val_o, 0);
    check("mid_rst_acc", m_acc, 0);
    check("mid_rst_sat", m_sat, 0);
    @(posedge clk);
    #3 srst = 1'b0;
    @(posedge clk);
    #1;
    put(24'h00007F, 1'b0, 1'b1);
    wait_main_val(k);
    check("post_rst_cnt", m_dout, 7);
    check("post_rst_acc", m_acc, 7);
    wait_drain();

    check("drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errs);
    $finish;
  end

endmodule

// File: doc/bit_population_counter_stream.md
# bit_population_counter_stream

Streaming population counter: each accepted WIDTH-bit word yields a count of its set (or clear) bits through a pipelined adder tree. Pipeline depth is a parameter, and the datapath carries full valid/ready backpressure. Beats are grouped into packets by a last flag, and the block reports a saturating per-packet running total. It replaces the fixed-latency, no-backpressure counter in the stream-statistics path and feeds downstream consumers that can stall.

## Interface
- WIDTH, 24: input word width in bits, ≥ 1.
- LEVELS_PER_STAGE, 1: adder-tree levels per pipeline register, ≥ 1.
- ACC_WIDTH, 16: per-packet accumulator width, ≥ CNT_W.
- Derived: CNT_W = $clog2(WIDTH+1); G = ceil(WIDTH/4) leaf groups; L = $clog2(G) tree levels; LAT = ceil(L/LEVELS_PER_STAGE) + 1.
- clk_i  in  1  single clock, all logic rising-edge.
- srst_i  in  1  reset, asynchronous, active-high.
- data_i  in  WIDTH  input word.
- mode_i  in  1  0 = count ones, 1 = count zeros; sampled with the beat.
- data_last_i  in  1  last beat of packet.
- data_val_i  in  1  input beat valid.
- data_ready_o  out  1  block can accept a beat.
- data_o  out  CNT_W  count for the output beat.
- data_last_o  out  1  output beat is last of its packet.
- data_val_o  out  1  output beat valid.
- data_ready_i  in  1  downstream accepts the output beat.
- acc_o  out  ACC_WIDTH  running packet total, including the current output beat.
- acc_sat_o  out  1  accumulator has saturated in the current packet.

## Operation
- Input transfer occurs on data_val_i & data_ready_o. Output transfer occurs on data_val_o & data_ready_i.
- Word is zero-extended to 4G bits. In mode 1, only the WIDTH real bits are inverted, so pad bits never count. Max count = WIDTH, so CNT_W must hold WIDTH exactly.
- Leaf: combinational 3-bit count per 4-bit group. Tree: L pairwise-add levels, each level's sum one bit wider. Odd operand at a level passes through unchanged.
- A register sits after every LEVELS_PER_STAGE levels; the final register is the output stage. Each stage carries valid, last, and count.
- Global stall: stall = data_val_o & ~data_ready_i. When stalled, every stage holds. data_ready_o = ~stall (combinational path from data_ready_i). Bubbles are not collapsed.
- Accumulator, updated when the output stage loads a valid beat:
  - If first-of-packet: acc = count.
  - Otherwise: acc = min(acc + count, 2^ACC_WIDTH − 1).
- first-of-packet is set by reset and by loading a beat with last = 1. It is cleared by loading a beat with last = 0.
- acc_sat_o is set when clamping occurs. It is sticky within the packet and recomputed on a first-of-packet load.
- Packets may be any length ≥ 1 beat. A single-beat packet gives acc_o = data_o.
- Simultaneous input and output transfer is allowed every cycle. Sustained throughput is one beat per clock when data_ready_i = 1.

## Timing
- Reset (async assert, sync release): all valids 0, data_o 0, data_last_o 0, acc_o 0, acc_sat_o 0, first-of-packet 1. data_ready_o = 1 from the first edge after release.
- Latency: a beat accepted at edge n appears on data_val_o after edge n+LAT−1 (LAT cycles of pipeline registers), provided there is no stall.
- Special case L = 0 (WIDTH ≤ 4): LAT = 1, output register only.
- Outputs are stable while data_val_o = 1 and data_ready_i = 0.
- Reset mid-packet discards all in-flight beats and the partial total. The next beat accepted starts a new packet.

## Structure
- Package bpc_pkg holds:
  - typedef enum logic {BPC_ONES, BPC_ZEROS} bpc_mode_t.
  - Functions cnt_w(width), tree_levels(width), latency(width, lps) for use by RTL and bench.
- One sub-module, bpc_adder_stage: parametrised by input operand count and operand width. It performs one combinational pairwise-add level. The top generates L instances and inserts registers per LEVELS_PER_STAGE.

## Test plan
- WIDTH=24, LPS=1 (LAT=4): data_i=24'hFFFFFF, mode 0, last=1 -> data_o=24, acc_o=24, data_val_o exactly 4 cycles after acceptance. Repeat with WIDTH=4: 4'hF -> 4, LAT=1.
- WIDTH=24: data_i=24'h00000F, mode 1 -> 20. WIDTH=22: data_i=0, mode 1 -> 22 (pad bits excluded).
- Packet of three beats with counts 1, 2, 3 (last on third), then a single-beat packet with count 5 -> acc_o = 1, 3, 6, then 5; data_last_o on beats 3 and 4 only.
- Continuous stream with data_ready_i low for 5 cycles mid-stream -> data_ready_o low for those same cycles; outputs held; no beat lost, duplicated or reordered; full rate resumes on the next cycle.
- ACC_WIDTH=5: two all-ones 24-bit beats in one packet -> acc_o = 24, then 31 with acc_sat_o=1. Next packet's first beat -> acc_o = its count, acc_sat_o = 0.
- srst_i asserted between clock edges with three beats in flight -> data_val_o and acc_o drop to 0 immediately. After release, the first beat (count 7, last=1) -> acc_o = 7.
